// File: rtl/fwd_select_ctrl_pkg.sv
// Shared select codes, shadow-stage record and write-match helper for the EX forwarding controller.
package fwd_select_ctrl_pkg;

    localparam int FWD_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_PWB = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_info_t;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic stage_writes(stage_info_t s, logic [FWD_ADDR_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_select_ctrl_match_prio.sv
// Priority encoder for one operand: the youngest in-flight producer of rs_i picks the mux input.
module fwd_match_prio
    import fwd_select_ctrl_pkg::*;
(
    input  logic [FWD_ADDR_W-1:0] rs_i,
    input  stage_info_t           ex_i,
    input  stage_info_t           mem_i,
    input  stage_info_t           wb_i,
    output logic [1:0]            sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (stage_writes(ex_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (stage_writes(mem_i, rs_i)) begin
            sel_o = FWD_WB;
        end else if (stage_writes(wb_i, rs_i)) begin
            sel_o = FWD_PWB;
        end
    end

endmodule

// File: rtl/fwd_select_ctrl.sv
// EX operand forwarding-select and load-use stall controller.
// Optional FWD_POST_WB_EN adds the WB shadow stage so a WB-only match selects the post-WB register (11).
// ADDR_W must equal FWD_ADDR_W from the package, which sizes the shadow-stage record.
module fwd_select_ctrl
    import fwd_select_ctrl_pkg::*;
#(
    parameter int ADDR_W = FWD_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    output logic              stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_info_t           ex_q, ex_d, mem_q, wb_stage;
    logic [FWD_ADDR_W-1:0] rs1, rs2, rd;
    logic                  hazard, ex_bubble;
    logic [1:0]            sel_a_d, sel_a_q, sel_b_d, sel_b_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    assign rs1 = FWD_ADDR_W'(id_rs1);
    assign rs2 = FWD_ADDR_W'(id_rs2);
    assign rd  = FWD_ADDR_W'(id_rd);

    // Only a load still in EX is too young to forward from; one bubble moves it to MEM.
    assign hazard = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                    (ex_q.rd != '0) && ((ex_q.rd == rs1) || (ex_q.rd == rs2));
    assign stall     = hazard && !flush;
    assign ex_bubble = !id_valid || flush || stall;

    always_comb begin
        ex_d = '0;
        if (!ex_bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

`ifdef FWD_POST_WB_EN
    stage_info_t wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= mem_q;
        end
    end

    assign wb_stage = wb_q;
`else
    // Write-first register file already covers a WB-only producer.
    assign wb_stage = '0;
`endif

    fwd_match_prio u_match_a (
        .rs_i  (rs1),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .wb_i  (wb_stage),
        .sel_o (sel_a_d)
    );

    fwd_match_prio u_match_b (
        .rs_i  (rs2),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .wb_i  (wb_stage),
        .sel_o (sel_b_d)
    );

    assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            sel_a_q <= ex_bubble ? FWD_RF : sel_a_d;
            sel_b_q <= ex_bubble ? FWD_RF : sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;
    assign ex_valid  = ex_q.valid;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed scoreboard bench for fwd_select_ctrl; the counter is narrowed so saturation is reachable quickly.
module tb_fwd_select_ctrl;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

`ifdef FWD_POST_WB_EN
    localparam logic [1:0] DIST3_SEL = 2'b11;
`else
    localparam logic [1:0] DIST3_SEL = 2'b00;
`endif

    typedef struct {
        string      tag;
        logic       exv;
        logic [1:0] sa;
        logic [1:0] sb;
    } exp_t;

    logic              clk, rst, flush, id_valid, id_reg_write, id_mem_read;
    logic [ADDR_W-1:0] id_rs1, id_rs2, id_rd;
    logic              stall, ex_valid;
    logic [1:0]        fwd_sel_a, fwd_sel_b;
    logic [CNT_W-1:0]  stall_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    fwd_select_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .ex_valid     (ex_valid),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbQ.pop_front();
            checkValue({e.tag, "/ex_valid"}, 32'(ex_valid), 32'(e.exv));
            checkValue({e.tag, "/sel_a"}, 32'(fwd_sel_a), 32'(e.sa));
            checkValue({e.tag, "/sel_b"}, 32'(fwd_sel_b), 32'(e.sb));
        end
    endtask

    // Drive one ID-stage slot, check the combinational stall, then check the EX-cycle outputs.
    task automatic applyStimulus(input string tag, input logic v, input int rs1, input int rs2,
                                 input int rd, input logic rw, input logic mr, input logic fl,
                                 input logic expStall, input logic expExv,
                                 input logic [1:0] expA, input logic [1:0] expB);
        exp_t e;
        id_valid     = v;
        id_rs1       = ADDR_W'(rs1);
        id_rs2       = ADDR_W'(rs2);
        id_rd        = ADDR_W'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        #1;
        checkValue({tag, "/stall"}, 32'(stall), 32'(expStall));
        e.tag = tag;
        e.exv = expExv;
        e.sa  = expA;
        e.sb  = expB;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_valid = 1'b0;
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd = '0;
        id_reg_write = 1'b0;
        id_mem_read = 1'b0;
        #12;
        checkValue("reset/ex_valid", 32'(ex_valid), 32'd0);
        checkValue("reset/sel_a", 32'(fwd_sel_a), 32'd0);
        checkValue("reset/sel_b", 32'(fwd_sel_b), 32'd0);
        checkValue("reset/stall_cnt", 32'(stall_cnt), 32'd0);
        checkValue("reset/stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //             tag        v  rs1 rs2 rd  rw mr fl  stall exv  A      B
        applyStimulus("alu_prod", 1, 1,  2,  5,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("alu_b2b",  1, 5,  6,  8,  1, 0, 0,  0,    1,  2'b01, 2'b00);

        applyStimulus("d2_prod",  1, 0,  0,  7,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("d2_gap",   1, 10, 11, 9,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("d2_cons",  1, 7,  0,  12, 1, 0, 0,  0,    1,  2'b10, 2'b00);

        applyStimulus("d3_prod",  1, 0,  0,  13, 1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("d3_gap1",  1, 0,  0,  14, 1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("d3_gap2",  1, 0,  0,  15, 1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("d3_cons",  1, 0,  13, 0,  0, 0, 0,  0,    1,  2'b00, DIST3_SEL);

        applyStimulus("lu_load",  1, 0,  0,  3,  1, 1, 0,  0,    1,  2'b00, 2'b00);
        checkValue("lu/cnt_before", 32'(stall_cnt), 32'd0);
        applyStimulus("lu_stall", 1, 1,  3,  16, 1, 0, 0,  1,    0,  2'b00, 2'b00);
        checkValue("lu/cnt_after", 32'(stall_cnt), 32'd1);
        applyStimulus("lu_fwd",   1, 1,  3,  16, 1, 0, 0,  0,    1,  2'b00, 2'b10);

        applyStimulus("x0_w1",    1, 0,  0,  0,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("x0_w2",    1, 0,  0,  0,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("x0_ld",    1, 0,  0,  0,  1, 1, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("x0_cons",  1, 0,  0,  4,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("prio_w4",  1, 0,  0,  4,  1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("prio_cons",1, 4,  4,  0,  0, 0, 0,  0,    1,  2'b01, 2'b01);

        applyStimulus("fl_load",  1, 0,  0,  20, 1, 1, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("fl_stall", 1, 20, 0,  0,  0, 0, 1,  0,    0,  2'b00, 2'b00);
        checkValue("fl/cnt", 32'(stall_cnt), 32'd1);
        applyStimulus("fl_next",  1, 20, 0,  0,  0, 0, 0,  0,    1,  2'b10, 2'b00);
        applyStimulus("idle",     0, 20, 0,  0,  0, 0, 0,  0,    0,  2'b00, 2'b00);

        applyStimulus("rs_p21",   1, 0,  0,  21, 1, 0, 0,  0,    1,  2'b00, 2'b00);
        applyStimulus("rs_p22",   1, 0,  0,  22, 1, 0, 0,  0,    1,  2'b00, 2'b00);
        id_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkValue("arst/ex_valid", 32'(ex_valid), 32'd0);
        checkValue("arst/sel_a", 32'(fwd_sel_a), 32'd0);
        checkValue("arst/sel_b", 32'(fwd_sel_b), 32'd0);
        checkValue("arst/stall_cnt", 32'(stall_cnt), 32'd0);
        #1;
        rst = 1'b0;
        applyStimulus("rs_cons",  1, 21, 22, 0,  0, 0, 0,  0,    1,  2'b00, 2'b00);

        // A self-dependent load stalls every other cycle; run well past 2^CNT_W + 2 stalls.
        id_valid = 1'b1;
        id_rs1 = ADDR_W'(3);
        id_rs2 = '0;
        id_rd = ADDR_W'(3);
        id_reg_write = 1'b1;
        id_mem_read = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 2 * ((1 << CNT_W) + 2) + 4; i++) begin
            @(posedge clk);
            #1;
        end
        checkValue("sat/stall_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
        checkValue("scoreboard/left", 32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
